spec_acc_sequencer: RTL
=======================

# spec_acc_sequencer

Control sequencer for the range-bin spectrum accumulator. It takes the FFT output beat stream, tracks the current range bin and pulse count, and generates matched read-side and write-side address/valid streams for the read-modify-write DPRAM accumulation path. The write side lags the read side by a fixed pipeline latency. The block sits between the FFT core and the spectrum accumulation/address logic, and signals when a full multi-pulse accumulation run is complete.

## Interface
Parameters:
- FFT_LEN, 1024, FFT points per range bin (frame length, power of 2)
- IDX_W, 10, log2(FFT_LEN)
- BIN_W, 5, range-bin counter width
- CNT_W, 16, pulse counter width
- RMW_LAT, 3, read-to-write latency of the accumulation datapath in cycles (≥1)

Ports:
- clk  in  1  system clock; the block has one clock
- rst  in  1  reset, synchronous and active-high
- acc_start  in  1  one-cycle pulse; latches config and starts a run
- acc_abort  in  1  level/pulse; terminates the run
- bin_num  in  BIN_W  range bins per pulse, including background bin 1 (legal 2..31)
- pulse_num  in  CNT_W  pulses to accumulate (legal ≥1)
- xk_valid  in  1  FFT output beat valid
- xk_index  in  IDX_W  FFT output bin index
- rd_en  out  1  DPRAM read strobe
- rd_index  out  IDX_W  read spectral index
- rd_bin  out  BIN_W  read range bin (1-based)
- data_valid  out  1  accumulate-and-write strobe
- data_index  out  IDX_W  write spectral index
- range_bin  out  BIN_W  write range bin (1-based)
- first_pulse  out  1  aligned with data_valid; accumulator uses 0 instead of RAM data
- busy  out  1  run in progress
- pulse_cnt  out  CNT_W  completed pulses in the current run
- acc_done  out  1  one-cycle run-complete pulse
- frame_err  out  1  sticky index-sequence error

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - acc_start with legal config latches bin_num/pulse_num, clears pulse_cnt and frame_err, sets bin=1 and expected index=0, and moves to RUN.
  - acc_start with bin_num<2 or pulse_num==0 is ignored.
- RUN:
  - Each xk_valid beat with xk_index==expected is accepted. It issues a read beat (rd_en=1, rd_index=xk_index, rd_bin=bin, first_pulse tag = (pulse_cnt==0)).
  - Gaps in xk_valid are stalls: no counters advance.
  - Mismatched index: beat dropped, frame_err set (sticky until next accepted acc_start), expected index unchanged.
- End of frame (accepted beat with index FFT_LEN-1):
  - Expected index wraps to 0.
  - If bin<bin_num, bin increments.
  - Otherwise bin wraps to 1 and pulse_cnt increments. If the new pulse_cnt==pulse_num, the state moves to FLUSH and no further beats are accepted.
- FLUSH: waits RMW_LAT cycles until the last write beat leaves, then moves to DONE.
- DONE: acc_done=1 for one cycle, then IDLE.
- Write side: {rd_en, rd_index, rd_bin, first_pulse tag} are delayed through an RMW_LAT-deep shift register to produce {data_valid, data_index, range_bin, first_pulse}.
- acc_abort (any state): next state IDLE, the delay line is cleared (no further data_valid), acc_done is not pulsed, and pulse_cnt holds its value.
- acc_start while busy: ignored.
- Simultaneous acc_start and acc_abort: abort wins.
- Counters use modulo arithmetic only at the stated wrap points. pulse_cnt never exceeds pulse_num.

## Timing
- Reset values: rd_en=0, rd_index=0, rd_bin=1, data_valid=0, data_index=0, range_bin=1, first_pulse=0, busy=0, pulse_cnt=0, acc_done=0, frame_err=0. State is IDLE and the delay line is zeroed.
- Reset asserted mid-run behaves as an abort plus a full clear.
- acc_start at cycle t: busy=1 at t+1. The first beat can be accepted at t+1.
- Accepted beat at cycle t: rd_* valid at t+1; data_valid/data_index/range_bin/first_pulse at t+1+RMW_LAT.
- Last write beat at cycle w: acc_done=1 at w+1, busy=0 at w+2 (busy still 1 during acc_done).
- pulse_cnt updates the cycle after the final beat of the last bin of a pulse.
- acc_abort at cycle t: busy=0 and data_valid=0 from t+1.

## Test plan
- FFT_LEN=8, bin_num=2, pulse_num=1, contiguous beats 0..7 twice:
  - rd stream bins 1,1…,2,2…; writes appear exactly RMW_LAT+1 cycles after each beat.
  - first_pulse=1 on all 16 writes; acc_done one cycle after the 16th write; pulse_cnt=1.
- FFT_LEN=8, bin_num=3, pulse_num=3, random xk_valid gaps:
  - 72 writes total; first_pulse=1 only on the first 24.
  - range_bin sequence 1,2,3 repeated; pulse_cnt steps 0→1→2→3; single acc_done.
- Index error: beat with xk_index=5 when 3 is expected:
  - frame_err=1 and no rd/write for that beat.
  - Resending 3 continues normally; frame_err stays 1 until the next acc_start.
- acc_abort mid-frame with RMW_LAT beats in flight:
  - data_valid=0 from the next cycle, busy=0, no acc_done, pulse_cnt held.
  - A new acc_start then restarts with pulse_cnt=0.
- Illegal config (bin_num=1, or pulse_num=0) with acc_start: busy stays 0 and all outputs stay at reset values.
- rst asserted during FLUSH: all outputs return to reset values next cycle and acc_done never pulses.

Source files
------------

// File: rtl/spec_acc_sequencer.sv
// Range-bin spectrum accumulator sequencer: turns the FFT beat stream into matched
// read-side and delayed write-side address/valid streams for a read-modify-write DPRAM.
module spec_acc_sequencer #(
  parameter int FFT_LEN = 1024,
  parameter int IDX_W   = 10,
  parameter int BIN_W   = 5,
  parameter int CNT_W   = 16,
  parameter int RMW_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_start,
  input  logic             acc_abort,
  input  logic [BIN_W-1:0] bin_num,
  input  logic [CNT_W-1:0] pulse_num,
  input  logic             xk_valid,
  input  logic [IDX_W-1:0] xk_index,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_index,
  output logic [BIN_W-1:0] rd_bin,
  output logic             data_valid,
  output logic [IDX_W-1:0] data_index,
  output logic [BIN_W-1:0] range_bin,
  output logic             first_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             acc_done,
  output logic             frame_err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
    logic [BIN_W-1:0] bin;
    logic             first;
  } beat_t;

  localparam beat_t BEAT_RESET = '{valid: 1'b0, index: '0, bin: BIN_W'(1), first: 1'b0};
  localparam int    FL_W       = $clog2(RMW_LAT + 1) + 1;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] bin_num_q;
  logic [CNT_W-1:0] pulse_num_q;
  logic [IDX_W-1:0] exp_idx;
  logic [BIN_W-1:0] bin;
  logic [FL_W-1:0]  flush_cnt;
  beat_t            rd_q;
  beat_t            pipe [RMW_LAT];

  logic cfg_ok, start_ok, beat_hit, accept, mismatch, frame_end, pulse_end, last_beat;

  always_comb begin
    cfg_ok    = (bin_num >= BIN_W'(2)) && (pulse_num != '0);
    start_ok  = (state == IDLE) && acc_start && cfg_ok && !acc_abort;
    beat_hit  = (state == RUN) && xk_valid && !acc_abort;
    accept    = beat_hit && (xk_index == exp_idx);
    mismatch  = beat_hit && (xk_index != exp_idx);
    frame_end = accept && (exp_idx == IDX_W'(FFT_LEN - 1));
    pulse_end = frame_end && (bin >= bin_num_q);
    last_beat = pulse_end && ((pulse_cnt + CNT_W'(1)) == pulse_num_q);
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc_start && cfg_ok) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = FLUSH;
      // One extra cycle beyond RMW_LAT so the final write beat has left before DONE.
      FLUSH:   if (flush_cnt == FL_W'(RMW_LAT)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (acc_abort) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bin_num_q   <= '0;
      pulse_num_q <= '0;
      exp_idx     <= '0;
      bin         <= BIN_W'(1);
      pulse_cnt   <= '0;
      frame_err   <= 1'b0;
      flush_cnt   <= '0;
      rd_q        <= BEAT_RESET;
      // NOTE: the delay line is a handful of flops, not a RAM, and must come up zeroed
      // so no phantom write strobe escapes after reset.
      for (int i = 0; i < RMW_LAT; i++) pipe[i] <= BEAT_RESET;
    end else begin
      state <= state_nxt;

      if (start_ok) begin
        bin_num_q   <= bin_num;
        pulse_num_q <= pulse_num;
        exp_idx     <= '0;
        bin         <= BIN_W'(1);
        pulse_cnt   <= '0;
        frame_err   <= 1'b0;
      end

      if (mismatch) frame_err <= 1'b1;

      if (accept) begin
        exp_idx <= frame_end ? '0 : exp_idx + IDX_W'(1);
        if (frame_end) begin
          if (pulse_end) begin
            bin       <= BIN_W'(1);
            pulse_cnt <= pulse_cnt + CNT_W'(1);
          end else begin
            bin <= bin + BIN_W'(1);
          end
        end
      end

      flush_cnt <= (state == FLUSH) ? flush_cnt + FL_W'(1) : '0;

      if (accept) rd_q <= '{valid: 1'b1, index: xk_index, bin: bin, first: (pulse_cnt == '0)};
      else        rd_q.valid <= 1'b0;

      pipe[0] <= rd_q;
      for (int i = 1; i < RMW_LAT; i++) pipe[i] <= pipe[i-1];

      // Abort drops everything in flight so no stale accumulate reaches the RAM.
      if (acc_abort) begin
        rd_q.valid <= 1'b0;
        for (int i = 0; i < RMW_LAT; i++) pipe[i] <= BEAT_RESET;
      end
    end
  end

  assign rd_en       = rd_q.valid;
  assign rd_index    = rd_q.index;
  assign rd_bin      = rd_q.bin;
  assign data_valid  = pipe[RMW_LAT-1].valid;
  assign data_index  = pipe[RMW_LAT-1].index;
  assign range_bin   = pipe[RMW_LAT-1].bin;
  assign first_pulse = pipe[RMW_LAT-1].valid & pipe[RMW_LAT-1].first;
  assign busy        = (state != IDLE);
  assign acc_done    = (state == DONE);

endmodule
